mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 87 ++++++++
 tb/tb_mem_port_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction outstanding.
module mem_port_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rsp_valid,
  input  logic        ls_valid,
  input  logic        ls_we,
  input  logic [3:0]  ls_be,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ready,
  output logic        ls_rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_LS = 2'd2;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(MAX_CONSEC + 1);
  logic [1:0] state;
  logic [WW-1:0] wait_cnt;
  logic [CW-1:0] consec_cnt;
  logic busy, fire, done;
  always_comb begin
    if_ready = state == IDLE && !rst && if_valid && (!ls_valid || consec_cnt == CW'(MAX_CONSEC));
    ls_ready = state == IDLE && !rst && ls_valid && !if_ready;
    busy = state != IDLE;
    // a late ack in the final wait cycle still wins over the timeout
    fire = busy && !mem_ack && wait_cnt == WW'(TIMEOUT - 1);
    done = busy && (mem_ack || fire);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      consec_cnt <= '0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_be <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      if_rsp_valid <= done && state == BUSY_IF;
      ls_rsp_valid <= done && state == BUSY_LS;
      rsp_err <= fire;
      rsp_rdata <= busy && mem_ack && !mem_we ? mem_rdata : '0;
      if (if_ready) begin
        state <= BUSY_IF;
        mem_req <= 1'b1;
        mem_we <= 1'b0;
        mem_be <= 4'hF;
        mem_addr <= if_addr;
        mem_wdata <= '0;
        wait_cnt <= '0;
        consec_cnt <= '0;
      end else if (ls_ready) begin
        state <= BUSY_LS;
        mem_req <= 1'b1;
        mem_we <= ls_we;
        mem_be <= ls_be;
        mem_addr <= ls_addr;
        mem_wdata <= ls_wdata;
        wait_cnt <= '0;
        if (if_valid && consec_cnt != CW'(MAX_CONSEC)) consec_cnt <= consec_cnt + 1'b1;
      end else if (done) begin
        state <= IDLE;
        mem_req <= 1'b0;
      end else if (busy) wait_cnt <= wait_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario tests for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  logic if_valid = 0, ls_valid = 0, ls_we = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0, mem_rdata = 0;
  logic [3:0] ls_be = 0;
  logic if_ready, if_rsp_valid, ls_ready, ls_rsp_valid, rsp_err;
  logic mem_req, mem_we;
  logic [3:0] mem_be;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  int vec = 0, errs = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_rsp_valid(if_rsp_valid),
    .ls_valid(ls_valid), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_rsp_valid(ls_rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; if_valid = 1; ls_valid = 1; mem_ack = 1;
    cyc(); cyc();
    vec++; if (if_ready !== 0 || ls_ready !== 0) begin errs++; $display("FAIL reset_ready: got %b%b want 00", if_ready, ls_ready); end
    vec++; if (mem_req !== 0 || mem_addr !== 0 || mem_be !== 0) begin errs++; $display("FAIL reset_mem: req=%b addr=%h be=%h want 0", mem_req, mem_addr, mem_be); end
    vec++; if (if_rsp_valid !== 0 || ls_rsp_valid !== 0 || rsp_err !== 0 || rsp_rdata !== 0) begin errs++; $display("FAIL reset_rsp: got %b%b%b %h want 0", if_rsp_valid, ls_rsp_valid, rsp_err, rsp_rdata); end
    if_valid = 0; ls_valid = 0; mem_ack = 0;
    cyc(); rst = 0; cyc();
  endtask

  task automatic test_fetch();
    if_valid = 1; if_addr = 32'h100; #1;
    vec++; if (if_ready !== 1 || ls_ready !== 0) begin errs++; $display("FAIL fetch_ready: got %b%b want 10", if_ready, ls_ready); end
    cyc(); if_valid = 0;
    vec++; if (mem_req !== 1 || mem_addr !== 32'h100 || mem_we !== 0 || mem_be !== 4'hF || mem_wdata !== 0) begin errs++; $display("FAIL fetch_mem: req=%b addr=%h we=%b be=%h wd=%h want 1 100 0 f 0", mem_req, mem_addr, mem_we, mem_be, mem_wdata); end
    cyc();
    vec++; if (mem_req !== 1 || if_rsp_valid !== 0) begin errs++; $display("FAIL fetch_hold2: req=%b rsp=%b want 1 0", mem_req, if_rsp_valid); end
    cyc();
    vec++; if (mem_req !== 1 || mem_addr !== 32'h100) begin errs++; $display("FAIL fetch_hold3: req=%b addr=%h want 1 100", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 32'h12345678;
    cyc(); mem_ack = 0;
    vec++; if (if_rsp_valid !== 1 || ls_rsp_valid !== 0 || rsp_err !== 0 || rsp_rdata !== 32'h12345678) begin errs++; $display("FAIL fetch_rsp: if=%b ls=%b err=%b data=%h want 1 0 0 12345678", if_rsp_valid, ls_rsp_valid, rsp_err, rsp_rdata); end
    vec++; if (mem_req !== 0) begin errs++; $display("FAIL fetch_req_drop: got %b want 0", mem_req); end
    cyc();
    vec++; if (if_rsp_valid !== 0) begin errs++; $display("FAIL fetch_pulse: got %b want 0", if_rsp_valid); end
  endtask

  task automatic test_store();
    ls_valid = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF; #1;
    vec++; if (ls_ready !== 1 || if_ready !== 0) begin errs++; $display("FAIL store_ready: got ls=%b if=%b want 1 0", ls_ready, if_ready); end
    cyc(); ls_valid = 0;
    vec++; if (mem_req !== 1 || mem_we !== 1 || mem_be !== 4'b0011 || mem_addr !== 32'h2000 || mem_wdata !== 32'hDEADBEEF) begin errs++; $display("FAIL store_mem: req=%b we=%b be=%b addr=%h wd=%h", mem_req, mem_we, mem_be, mem_addr, mem_wdata); end
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    cyc(); mem_ack = 0;
    vec++; if (ls_rsp_valid !== 1 || if_rsp_valid !== 0 || rsp_rdata !== 0 || rsp_err !== 0) begin errs++; $display("FAIL store_rsp: ls=%b if=%b data=%h err=%b want 1 0 0 0", ls_rsp_valid, if_rsp_valid, rsp_rdata, rsp_err); end
    ls_we = 0;
  endtask

  task automatic test_arbitration();
    logic [5:0] pat;
    pat = 6'b010000;
    if_valid = 1; ls_valid = 1; ls_we = 0; if_addr = 32'h40; ls_addr = 32'h80; #1;
    for (int i = 0; i < 6; i++) begin
      vec++; if (if_ready !== pat[i] || ls_ready !== !pat[i]) begin errs++; $display("FAIL arb_grant%0d: if=%b ls=%b want if=%b", i, if_ready, ls_ready, pat[i]); end
      cyc(); mem_ack = 1;
      cyc(); mem_ack = 0;
      vec++; if (if_rsp_valid !== pat[i] || ls_rsp_valid !== !pat[i]) begin errs++; $display("FAIL arb_rsp%0d: if=%b ls=%b want if=%b", i, if_rsp_valid, ls_rsp_valid, pat[i]); end
    end
    if_valid = 0; ls_valid = 0;
  endtask

  task automatic test_timeout();
    mem_rdata = 32'hAAAA5555;
    ls_valid = 1; ls_we = 0; ls_addr = 32'h3000; #1;
    cyc(); ls_valid = 0;
    for (int k = 0; k < 15; k++) begin
      vec++; if (mem_req !== 1 || ls_rsp_valid !== 0) begin errs++; $display("FAIL to_wait%0d: req=%b rsp=%b want 1 0", k, mem_req, ls_rsp_valid); end
      cyc();
    end
    vec++; if (mem_req !== 0 || ls_rsp_valid !== 1 || rsp_err !== 1 || rsp_rdata !== 0) begin errs++; $display("FAIL to_fire: req=%b rsp=%b err=%b data=%h want 0 1 1 0", mem_req, ls_rsp_valid, rsp_err, rsp_rdata); end
    cyc();
    ls_valid = 1; #1;
    cyc(); ls_valid = 0;
    repeat (14) cyc();
    vec++; if (mem_req !== 1) begin errs++; $display("FAIL to_late_hold: req=%b want 1", mem_req); end
    mem_ack = 1;
    cyc(); mem_ack = 0;
    vec++; if (ls_rsp_valid !== 1 || rsp_err !== 0 || rsp_rdata !== 32'hAAAA5555 || mem_req !== 0) begin errs++; $display("FAIL to_late_ack: rsp=%b err=%b data=%h req=%b want 1 0 aaaa5555 0", ls_rsp_valid, rsp_err, rsp_rdata, mem_req); end
    cyc();
  endtask

  task automatic test_reset_mid();
    ls_valid = 1; ls_we = 1; ls_addr = 32'h4000; #1;
    cyc(); ls_valid = 0;
    cyc();
    rst = 1;
    cyc(); rst = 0;
    vec++; if (mem_req !== 0 || ls_rsp_valid !== 0) begin errs++; $display("FAIL rstmid_req: req=%b rsp=%b want 0 0", mem_req, ls_rsp_valid); end
    mem_ack = 1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      vec++; if (ls_rsp_valid !== 0 || if_rsp_valid !== 0 || mem_req !== 0) begin errs++; $display("FAIL rstmid_ack%0d: ls=%b if=%b req=%b want 0 0 0", k, ls_rsp_valid, if_rsp_valid, mem_req); end
    end
    mem_ack = 0; ls_we = 0;
    if_valid = 1; #1;
    vec++; if (if_ready !== 1) begin errs++; $display("FAIL rstmid_idle: if_ready=%b want 1", if_ready); end
    if_valid = 0;
    cyc();
  endtask

  task automatic test_spurious_ack();
    mem_ack = 1; mem_rdata = 32'h5A5A5A5A;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vec++; if (if_rsp_valid !== 0 || ls_rsp_valid !== 0 || mem_req !== 0) begin errs++; $display("FAIL spurious%0d: if=%b ls=%b req=%b want 0 0 0", k, if_rsp_valid, ls_rsp_valid, mem_req); end
    end
    mem_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_arbitration();
    test_timeout();
    test_reset_mid();
    test_spurious_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
